// File: rtl/conv_enc_pkg.sv
// Shared constants, state type and helpers for the K=4 rate-1/2 convolutional encoder.
// The CONV_ENC_PUNCT_EN build uses punct_mask() for the rate-2/3 puncture pattern.
package conv_enc_pkg;

    localparam int unsigned K       = 4;
    localparam int unsigned STATE_W = K - 1;

    localparam logic [K-1:0] G0_DEF = 4'b1111;
    localparam logic [K-1:0] G1_DEF = 4'b1101;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} conv_enc_state_t;

    // Puncture pattern [11;10]: even symbols send both bits, odd symbols drop c1.
    localparam logic [1:0] PUNCT [2] = '{2'b11, 2'b01};

    function automatic logic conv_parity(input logic [K-1:0] poly, input logic [K-1:0] tapvec);
        return ^(poly & tapvec);
    endfunction

    function automatic logic [1:0] punct_mask(input logic idx);
        return PUNCT[idx];
    endfunction

endpackage

// File: rtl/conv_enc_if.sv
// Bit-in / symbol-out handshake bundle for conv_encoder.
// The encoder uses the slave modport; the bit source and sink side uses master.
interface conv_enc_if;
    logic       enable;
    logic       in_bit;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [1:0] out_sym;
    logic [1:0] out_mask;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport slave (
        input  enable, in_bit, in_valid, in_last, out_ready,
        output in_ready, out_sym, out_mask, out_valid, out_last
    );

    modport master (
        output enable, in_bit, in_valid, in_last, out_ready,
        input  in_ready, out_sym, out_mask, out_valid, out_last
    );
endinterface

// File: rtl/conv_enc_core.sv
// Encoder shift register plus parity generation; o_sym = {c1, c0} for the current input u.
// The register advances only on i_step, and i_clear has priority over i_step.
module conv_enc_core
    import conv_enc_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_step,
    input  logic               i_u,
    output logic [1:0]         o_sym,
    output logic [STATE_W-1:0] o_state
);

    logic [STATE_W-1:0] r_sreg;
    logic [K-1:0]       w_taps;

    // Tap vector {u, r[0], r[1], r[2]}: the bit-reversed state follows u.
    assign w_taps = {i_u, {<<{r_sreg}}};
    assign o_sym  = {conv_parity(G1, w_taps), conv_parity(G0, w_taps)};
    assign o_state = r_sreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_clear) begin
            r_sreg <= '0;
        end else if (i_step) begin
            r_sreg <= {r_sreg[STATE_W-2:0], i_u};
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=4 convolutional encoder with frame FSM, zero-tail termination and one output register.
// Optional `CONV_ENC_PUNCT_EN: rate-2/3 puncturing through out_mask.
module conv_encoder
    import conv_enc_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic      clk,
    input  logic      rst,
    conv_enc_if.slave bus
);

    conv_enc_state_t r_state, w_state_nxt;
    logic [1:0]      r_tail_cnt, w_tail_cnt_nxt;
    logic            r_out_valid, r_out_last;
    logic [1:0]      r_out_sym, r_out_mask;

    logic       w_adv, w_in_ready, w_accept, w_tail_go, w_step, w_u, w_tail_end;
    logic [1:0] w_sym, w_mask;
    logic [STATE_W-1:0] w_enc_state;

    assign w_adv      = !r_out_valid || bus.out_ready;
    assign w_in_ready = w_adv && bus.enable && (r_state == IDLE || r_state == DATA);
    assign w_accept   = w_in_ready && bus.in_valid;
    assign w_tail_go  = w_adv && bus.enable && (r_state == TAIL);
    assign w_step     = w_accept || w_tail_go;
    assign w_u        = (r_state == TAIL) ? 1'b0 : bus.in_bit;
    assign w_tail_end = w_tail_go && (r_tail_cnt == 2'd2);

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!bus.enable),
        .i_step  (w_step),
        .i_u     (w_u),
        .o_sym   (w_sym),
        .o_state (w_enc_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tail_cnt <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_tail_cnt <= w_tail_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tail_cnt_nxt = r_tail_cnt;
        if (!bus.enable) begin
            w_state_nxt    = IDLE;
            w_tail_cnt_nxt = 2'd0;
        end else begin
            unique case (r_state)
                IDLE, DATA: begin
                    if (w_accept) begin
                        w_state_nxt = bus.in_last ? TAIL : DATA;
                    end
                end
                TAIL: begin
                    if (w_tail_go) begin
                        if (w_tail_end) begin
                            w_state_nxt    = IDLE;
                            w_tail_cnt_nxt = 2'd0;
                        end else begin
                            w_tail_cnt_nxt = r_tail_cnt + 2'd1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef CONV_ENC_PUNCT_EN
    logic r_idx;

    // Only the parity of the symbol index matters for a period-2 pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 1'b0;
        end else if (!bus.enable) begin
            r_idx <= 1'b0;
        end else if (w_step) begin
            r_idx <= w_tail_end ? 1'b0 : ~r_idx;
        end
    end

    assign w_mask = punct_mask(r_idx);
`else
    assign w_mask = 2'b11;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sym   <= 2'b00;
            r_out_mask  <= 2'b00;
            r_out_last  <= 1'b0;
        end else if (!bus.enable) begin
            r_out_valid <= 1'b0;
            r_out_sym   <= 2'b00;
            r_out_mask  <= 2'b00;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_step;
            if (w_step) begin
                r_out_sym  <= w_sym;
                r_out_mask <= w_mask;
                r_out_last <= w_tail_end;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sym   = r_out_sym;
    assign bus.out_mask  = r_out_mask;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed self-checking bench for conv_encoder: frames, backpressure, single-bit frame,
// abort via enable, and asynchronous reset in the middle of a tail.
module tb_conv_encoder;

    logic clk;
    logic rst;

    conv_enc_if bus();

    conv_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [1:0] got_sym[$];
    logic [1:0] got_mask[$];
    logic       got_last[$];
    int         stall_errs;
    int         stall_checks;
    int         tail_rdy_hi;
    bit         timed_out;

    localparam logic [1:0] E_FRAME [7] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    localparam logic [1:0] E_SINGLE [4] = '{2'b11, 2'b11, 2'b01, 2'b11};
`ifdef CONV_ENC_PUNCT_EN
    localparam logic [1:0] E_MASK [7] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
`else
    localparam logic [1:0] E_MASK [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
`endif

    // Drives one frame (bits[0] first) and records every symbol transferred downstream.
    task automatic drive_frame(input logic [7:0] bits, input int n, input bit toggle);
        int  sent = 0;
        int  cyc = 0;
        bit  done = 0;
        bit  held = 0;
        logic [1:0] held_sym = 2'b00;
        got_sym.delete();
        got_mask.delete();
        got_last.delete();
        stall_errs = 0;
        stall_checks = 0;
        tail_rdy_hi = 0;
        timed_out = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            bus.enable    = 1'b1;
            bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.in_valid  = (sent < n);
            bus.in_bit    = (sent < n) ? bits[sent] : 1'b0;
            bus.in_last   = (sent == n - 1);
            #1;
            if (held && bus.out_valid) begin
                stall_checks++;
                if (bus.out_sym !== held_sym) stall_errs++;
            end
            held     = bus.out_valid && !bus.out_ready;
            held_sym = bus.out_sym;
            if (sent == n && bus.in_ready && !(bus.out_valid && bus.out_last)) tail_rdy_hi++;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                got_sym.push_back(bus.out_sym);
                got_mask.push_back(bus.out_mask);
                got_last.push_back(bus.out_last);
                if (bus.out_last) done = 1;
            end
            cyc++;
        end
        if (!done) timed_out = 1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.in_bit = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_sym !== 2'b00) begin
            errors++;
            $display("FAIL reset_out_sym: got %b want 00", bus.out_sym);
        end
        checks++;
        if (bus.out_mask !== 2'b00 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mask_last: got %b/%b want 00/0", bus.out_mask, bus.out_last);
        end
        checks++;
        if (dut.u_core.r_sreg !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got %b want 000", dut.u_core.r_sreg);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_frame(input string name);
        checks++;
        if (timed_out || got_sym.size() != 7) begin
            errors++;
            $display("FAIL %s_count: got %0d symbols (timeout=%0b) want 7", name, got_sym.size(),
                     timed_out);
        end
        for (int i = 0; i < 7; i++) begin
            if (i < got_sym.size()) begin
                checks++;
                if (got_sym[i] !== E_FRAME[i] || got_mask[i] !== E_MASK[i] ||
                    got_last[i] !== (i == 6)) begin
                    errors++;
                    $display("FAIL %s_sym%0d: got sym=%b mask=%b last=%b want sym=%b mask=%b last=%b",
                             name, i, got_sym[i], got_mask[i], got_last[i], E_FRAME[i], E_MASK[i],
                             i == 6);
                end
            end
        end
    endtask

    task automatic test_frame_basic();
        drive_frame(8'b0000_1101, 4, 1'b0);
        check_frame("basic");
        checks++;
        if (dut.u_core.r_sreg !== 3'b000) begin
            errors++;
            $display("FAIL basic_end_state: got %b want 000", dut.u_core.r_sreg);
        end
    endtask

    task automatic test_backpressure();
        drive_frame(8'b0000_1101, 4, 1'b1);
        check_frame("stall");
        checks++;
        if (stall_errs !== 0 || stall_checks == 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d changes in %0d stalled cycles want 0 changes",
                     stall_errs, stall_checks);
        end
    endtask

    task automatic test_single_bit();
        drive_frame(8'b0000_0001, 1, 1'b0);
        checks++;
        if (timed_out || got_sym.size() != 4) begin
            errors++;
            $display("FAIL single_count: got %0d symbols want 4", got_sym.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < got_sym.size()) begin
                checks++;
                if (got_sym[i] !== E_SINGLE[i] || got_mask[i] !== E_MASK[i] ||
                    got_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL single_sym%0d: got sym=%b mask=%b last=%b want sym=%b mask=%b last=%b",
                             i, got_sym[i], got_mask[i], got_last[i], E_SINGLE[i], E_MASK[i],
                             i == 3);
                end
            end
        end
        checks++;
        if (tail_rdy_hi !== 0) begin
            errors++;
            $display("FAIL single_tail_ready: got in_ready high %0d tail cycles want 0",
                     tail_rdy_hi);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bit    = 1'b1;
        @(negedge clk);
        bus.in_bit    = 1'b0;
        @(negedge clk);
        bus.enable    = 1'b0;
        bus.in_bit    = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || dut.u_core.r_sreg !== 3'b000) begin
            errors++;
            $display("FAIL abort_clear: got valid=%b state=%b want 0/000", bus.out_valid,
                     dut.u_core.r_sreg);
        end
        bus.enable   = 1'b1;
        bus.in_valid = 1'b0;
        drive_frame(8'b0000_1101, 4, 1'b0);
        check_frame("after_abort");
    endtask

    task automatic test_reset_mid_tail();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bit    = 1'b1;
        bus.in_last   = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_sym !== 2'b00 || bus.out_mask !== 2'b00 ||
            bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b sym=%b mask=%b last=%b want all 0",
                     bus.out_valid, bus.out_sym, bus.out_mask, bus.out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_frame(8'b0000_1101, 4, 1'b0);
        check_frame("after_rst");
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_backpressure();
        test_single_bit();
        test_abort();
        test_reset_mid_tail();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
